// File: rtl/ibex_pkg.sv
// Shared definitions for the dummy-instruction retire monitor.
// Contents: OPCODE_OP, the dummy op enum (ADD/MUL/DIV/AND), the funct7/funct3
// pair for each dummy op, and a helper that checks a dummy encoding.
package ibex_pkg;

  localparam logic [6:0] OPCODE_OP = 7'h33;

  typedef enum logic [1:0] {
    DUMMY_ADD = 2'b00,
    DUMMY_MUL = 2'b01,
    DUMMY_DIV = 2'b10,
    DUMMY_AND = 2'b11
  } dummy_op_e;

  localparam logic [6:0] FUNCT7_ADD = 7'h00;
  localparam logic [6:0] FUNCT7_MUL = 7'h01;
  localparam logic [6:0] FUNCT7_DIV = 7'h01;
  localparam logic [6:0] FUNCT7_AND = 7'h00;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_MUL = 3'b000;
  localparam logic [2:0] FUNCT3_DIV = 3'b100;
  localparam logic [2:0] FUNCT3_AND = 3'b111;

  // {funct7, funct3} that identifies each dummy op
  function automatic logic [9:0] dummy_funct(dummy_op_e op);
    logic [9:0] f;
    case (op)
      DUMMY_ADD: f = {FUNCT7_ADD, FUNCT3_ADD};
      DUMMY_MUL: f = {FUNCT7_MUL, FUNCT3_MUL};
      DUMMY_DIV: f = {FUNCT7_DIV, FUNCT3_DIV};
      default:   f = {FUNCT7_AND, FUNCT3_AND};
    endcase
    return f;
  endfunction

  // Dummies must be register-register ops writing x0; rs1/rs2 are free.
  function automatic logic dummy_instr_ok(logic [31:0] instr);
    logic funct_ok;
    funct_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({instr[31:25], instr[14:12]} == dummy_funct(dummy_op_e'(i[1:0]))) funct_ok = 1'b1;
    end
    return funct_ok && (instr[6:0] == OPCODE_OP) && (instr[11:7] == 5'd0);
  endfunction

endpackage

// File: rtl/ibex_dummy_tag_fifo.sv
// In-order 1-bit tag queue between ID accept and retire.
// Ports: push_i/tag_i enqueue, pop_i dequeues the head, clear_i empties the
// queue (after any same-cycle pop); head_o is the head tag (0 when empty),
// full_o/empty_o/count_o report occupancy.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ibex_dummy_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        tag_i,
  input  logic        pop_i,
  input  logic        clear_i,
  output logic        head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = ~empty_o & mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= tag_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ibex_dummy_instr_monitor.sv
// Retire-side monitor for dummy-instruction insertion.
// Tags each instruction accepted into ID as dummy/real, pops the tag at
// retire, suppresses instret for dummies, checks dummy encodings and raises
// a sticky alarm on malformed dummies or tag-queue over/underflow.
// Ports: id_accept_i/insert_dummy_instr_i/dummy_instr_data_i (ID side),
// instr_retire_i/flush_i (retire side), retire_is_dummy_o/instret_en_o
// (combinational), inflight_o, alarm_o, dummy_retired_cnt_o.
// Optional: define IBEX_DUMMY_MON_CNT_EN to build the saturating counter of
// retired dummies; otherwise dummy_retired_cnt_o is tied to 0.
module ibex_dummy_instr_monitor
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     id_accept_i,
  input  logic                     insert_dummy_instr_i,
  input  logic [31:0]              dummy_instr_data_i,
  input  logic                     instr_retire_i,
  input  logic                     flush_i,
  output logic                     retire_is_dummy_o,
  output logic                     instret_en_o,
  output logic [$clog2(DEPTH):0]   inflight_o,
  output logic                     alarm_o,
  output logic [CNT_W-1:0]         dummy_retired_cnt_o
);

  logic head_tag, q_full, q_empty;
  logic enc_bad, overflow, underflow;
  logic alarm_q;

  // A flush kills the instruction entering ID, so it never enters the queue.
  ibex_dummy_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (id_accept_i & ~flush_i),
    .tag_i   (insert_dummy_instr_i),
    .pop_i   (instr_retire_i),
    .clear_i (flush_i),
    .head_o  (head_tag),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (inflight_o)
  );

  assign retire_is_dummy_o = head_tag;
  assign instret_en_o      = instr_retire_i & ~head_tag;

  assign enc_bad   = id_accept_i & insert_dummy_instr_i & ~dummy_instr_ok(dummy_instr_data_i);
  assign overflow  = id_accept_i & ~flush_i & q_full & ~instr_retire_i;
  assign underflow = instr_retire_i & q_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) alarm_q <= 1'b0;
    else         alarm_q <= alarm_q | enc_bad | overflow | underflow;
  end

  assign alarm_o = alarm_q;

`ifdef IBEX_DUMMY_MON_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  cnt_q <= '0;
    else if (instr_retire_i & head_tag & ~&cnt_q) cnt_q <= cnt_q + 1'b1;
  end

  assign dummy_retired_cnt_o = cnt_q;
`else
  assign dummy_retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_dummy_instr_monitor.sv
module tb_ibex_dummy_instr_monitor;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              id_accept_i = 1'b0;
  logic              insert_dummy_instr_i = 1'b0;
  logic [31:0]       dummy_instr_data_i = '0;
  logic              instr_retire_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              retire_is_dummy_o;
  logic              instret_en_o;
  logic [$clog2(DEPTH):0] inflight_o;
  logic              alarm_o;
  logic [CNT_W-1:0]  dummy_retired_cnt_o;

  ibex_dummy_instr_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .id_accept_i          (id_accept_i),
    .insert_dummy_instr_i (insert_dummy_instr_i),
    .dummy_instr_data_i   (dummy_instr_data_i),
    .instr_retire_i       (instr_retire_i),
    .flush_i              (flush_i),
    .retire_is_dummy_o    (retire_is_dummy_o),
    .instret_en_o         (instret_en_o),
    .inflight_o           (inflight_o),
    .alarm_o              (alarm_o),
    .dummy_retired_cnt_o  (dummy_retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // reference model: in-order queue of tags, sticky alarm, saturating count
  bit tq[$];
  bit m_alarm;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // legal dummy: fixed bits (everything except rs1/rs2) match one of four patterns
  function automatic bit enc_legal(input logic [31:0] d);
    logic [31:0] m;
    m = d & 32'hFE007FFF;
    return (m == 32'h00000033) || (m == 32'h02000033) ||
           (m == 32'h02004033) || (m == 32'h00007033);
  endfunction

  function automatic logic [31:0] legal_dummy();
    logic [31:0] base [4];
    base[0] = 32'h00000033; base[1] = 32'h02000033;
    base[2] = 32'h02004033; base[3] = 32'h00007033;
    return base[$urandom_range(3)] | ($urandom() & 32'h01FF8000);
  endfunction

  task automatic step(input bit acc, input bit ins, input logic [31:0] data,
                      input bit ret, input bit fl);
    bit exp_head;
    int pre;
    @(negedge clk_i);
    id_accept_i = acc; insert_dummy_instr_i = ins; dummy_instr_data_i = data;
    instr_retire_i = ret; flush_i = fl;
    #1;
    exp_head = (tq.size() > 0) ? tq[0] : 1'b0;
    chk("retire_is_dummy", {31'd0, retire_is_dummy_o}, {31'd0, exp_head});
    chk("instret_en", {31'd0, instret_en_o}, {31'd0, ret & ~exp_head});
    chk("inflight", 32'(inflight_o), 32'(tq.size()));
    chk("alarm", {31'd0, alarm_o}, {31'd0, m_alarm});
    chk("dummy_cnt", 32'(dummy_retired_cnt_o), 32'(m_cnt));
    @(posedge clk_i);
    pre = tq.size();
    if (acc && ins && !enc_legal(data)) m_alarm = 1'b1;
    if (ret) begin
      if (pre == 0) m_alarm = 1'b1;
      else begin
`ifdef IBEX_DUMMY_MON_CNT_EN
        if (tq[0] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
        void'(tq.pop_front());
      end
    end
    if (acc && !fl) begin
      if (pre == DEPTH && !ret) m_alarm = 1'b1;
      else tq.push_back(ins);
    end
    if (fl) tq.delete();
  endtask

  task automatic idle(); step(0, 0, 32'h0, 0, 0); endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    id_accept_i = 0; insert_dummy_instr_i = 0; dummy_instr_data_i = '0;
    instr_retire_i = 0; flush_i = 0;
    #2;
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_alarm", {31'd0, alarm_o}, 32'd0);
    chk("rst_cnt", 32'(dummy_retired_cnt_o), 32'd0);
    chk("rst_head", {31'd0, retire_is_dummy_o}, 32'd0);
    rst_ni = 1'b1;
    tq.delete(); m_alarm = 0; m_cnt = 0;
  endtask

  initial begin
    do_reset();

    // normal then dummy, retire both
    step(1, 0, 32'hFFFFFFFF, 0, 0);
    step(1, 1, 32'h00208033, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle();

    // legal MUL/DIV/AND dummies, then rd=1
    step(1, 1, 32'h02208033, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 32'h0220C033, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 32'h0020F033, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 32'h002080B3, 0, 0);
    idle();
    chk("enc_rd1_alarm", {31'd0, alarm_o}, 32'd1);
    do_reset();

    // full queue: push with retire is fine, push without retire overflows
    step(1, 0, 0, 0, 0);
    step(1, 1, 32'h00208033, 0, 0);
    step(1, 0, 0, 1, 0);
    idle();
    chk("full_pushpop_no_alarm", {31'd0, alarm_o}, 32'd0);
    step(1, 1, 32'h00208033, 0, 0);
    idle();
    chk("overflow_alarm", {31'd0, alarm_o}, 32'd1);
    chk("overflow_inflight", 32'(inflight_o), 32'd2);
    do_reset();

    // flush with retire and accept
    step(1, 1, 32'h00208033, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    idle();
    chk("flush_inflight", 32'(inflight_o), 32'd0);

    // retire on empty queue, alarm sticks until reset
    step(0, 0, 0, 1, 0);
    idle(); idle(); idle();
    chk("underflow_alarm", {31'd0, alarm_o}, 32'd1);
    do_reset();

    // dummy retire counter saturation
    for (int i = 0; i < 5; i++) begin
      step(1, 1, legal_dummy(), 0, 0);
      step(0, 0, 0, 1, 0);
    end
    idle();

    // randomized traffic with periodic resets
    for (int c = 0; c < 1500; c++) begin
      bit acc, ins, ret, fl;
      logic [31:0] data;
      if (c % 120 == 119) do_reset();
      acc  = $urandom_range(1);
      ins  = ($urandom_range(2) == 0);
      data = ($urandom_range(5) == 0) ? $urandom() : legal_dummy();
      ret  = (tq.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      fl   = ($urandom_range(11) == 0);
      step(acc, ins, data, ret, fl);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
